// File: rtl/pio_shift_out_595_if.sv
// Parallel PIO value in; 3-wire 74HC595 link (sclk/sdata/rclk) and transfer status out.
// Registered outputs are driven by the serializer. The serializer applies no backpressure to data_in.
// The serializer always converges to the latest data_in value.
interface pio_shift_out_595_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              sclk;
    logic              sdata;
    logic              rclk;
    logic              busy;
    logic              xfer_done;

    modport master (output data_in, input sclk, sdata, rclk, busy, xfer_done);
    modport slave  (input data_in, output sclk, sdata, rclk, busy, xfer_done);
endinterface

// File: rtl/pio_shift_out_595.sv
// Serializes every change of the PIO port into a 74HC595-style shift+latch register.
// Latency: busy rises 1 edge after a change; a frame lasts (2*DATA_W+1)*CLK_DIV cycles.
// No backpressure: changes during a frame are collapsed, and only the newest value is sent next.
module pio_shift_out_595 #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    pio_shift_out_595_if.slave bus
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SHIFT_LOW  = 2'd1;
    localparam logic [1:0] ST_SHIFT_HIGH = 2'd2;
    localparam logic [1:0] ST_LATCH      = 2'd3;

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] sent_q, sent_d;
    logic              refresh_q, refresh_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              rclk_q, rclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] shreg_next;
    logic              div_end;
    logic              start;
    logic              first_bit;
    logic              next_bit;

    assign div_end    = (div_cnt_q == DIV_LAST);
    assign start      = refresh_q || (bus.data_in != sent_q);
    assign shreg_next = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
    assign first_bit  = (MSB_FIRST != 0) ? bus.data_in[DATA_W-1] : bus.data_in[0];
    assign next_bit   = (MSB_FIRST != 0) ? shreg_next[DATA_W-1]  : shreg_next[0];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        sent_d    = sent_q;
        refresh_d = refresh_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        rclk_d    = rclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = bus.data_in;
                    sent_d    = bus.data_in;
                    refresh_d = 1'b0;
                    sdata_d   = first_bit;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT_LOW;
                end
            end
            ST_SHIFT_LOW: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    state_d   = ST_SHIFT_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_SHIFT_HIGH: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        rclk_d  = 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        // sdata moves only with the falling sclk so it is stable across the high window
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shreg_d   = shreg_next;
                        sdata_d   = next_bit;
                        state_d   = ST_SHIFT_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_LATCH: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    rclk_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // refresh_q comes out of reset set so the external register's power-up garbage is overwritten
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            sent_q    <= '0;
            refresh_q <= 1'b1;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            rclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            sent_q    <= sent_d;
            refresh_q <= refresh_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            rclk_q    <= rclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.sdata     = sdata_q;
    assign bus.rclk      = rclk_q;
    assign bus.busy      = busy_q;
    assign bus.xfer_done = done_q;

endmodule

// File: tb/tb_pio_shift_out_595.sv
// Directed bench: default instance plus MSB_FIRST=0 and CLK_DIV=1 corner instances.
module tb_pio_shift_out_595;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    pio_shift_out_595_if #(.DATA_W(8)) if0 ();
    pio_shift_out_595_if #(.DATA_W(8)) if1 ();
    pio_shift_out_595_if #(.DATA_W(8)) if2 ();

    pio_shift_out_595 #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    pio_shift_out_595 #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(0)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    pio_shift_out_595 #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    wire [2:0] busy_w  = {if2.busy,      if1.busy,      if0.busy};
    wire [2:0] sclk_w  = {if2.sclk,      if1.sclk,      if0.sclk};
    wire [2:0] sdata_w = {if2.sdata,     if1.sdata,     if0.sdata};
    wire [2:0] rclk_w  = {if2.rclk,      if1.rclk,      if0.rclk};
    wire [2:0] done_w  = {if2.xfer_done, if1.xfer_done, if0.xfer_done};

    int busy_run[3], busy_len[3], busy_cyc[3], n_xfer[3], gap_run[3], gap[3];
    int n_rise[3], xfer_rises[3], first_lat[3], sclk_run[3], sclk_hi[3];
    int rclk_run[3], rclk_wid[3], n_rclk[3], done_run[3], done_wid[3], n_done[3];
    logic [31:0] bits[3] = '{default: '0};
    logic [2:0] pb = '0, ps = '0, pr = '0, px = '0;

    // Per-cycle monitor, sampled on the falling edge while registered outputs are stable
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_w[i]) begin
                busy_run[i] <= busy_run[i] + 1;
                busy_cyc[i] <= busy_cyc[i] + 1;
            end else begin
                gap_run[i] <= gap_run[i] + 1;
            end
            if (busy_w[i] && !pb[i]) begin
                gap[i]        <= gap_run[i];
                gap_run[i]    <= 0;
                xfer_rises[i] <= 0;
            end
            if (!busy_w[i] && pb[i]) begin
                busy_len[i] <= busy_run[i];
                busy_run[i] <= 0;
                n_xfer[i]   <= n_xfer[i] + 1;
            end
            if (sclk_w[i]) sclk_run[i] <= sclk_run[i] + 1;
            else           sclk_run[i] <= 0;
            if (!sclk_w[i] && ps[i]) sclk_hi[i] <= sclk_run[i];
            if (sclk_w[i] && !ps[i]) begin
                n_rise[i] <= n_rise[i] + 1;
                bits[i]   <= {bits[i][30:0], sdata_w[i]};
                if (xfer_rises[i] == 0) first_lat[i] <= busy_run[i];
                xfer_rises[i] <= xfer_rises[i] + 1;
            end
            if (rclk_w[i]) rclk_run[i] <= rclk_run[i] + 1;
            else           rclk_run[i] <= 0;
            if (!rclk_w[i] && pr[i]) begin
                rclk_wid[i] <= rclk_run[i];
                n_rclk[i]   <= n_rclk[i] + 1;
            end
            if (done_w[i]) done_run[i] <= done_run[i] + 1;
            else           done_run[i] <= 0;
            if (!done_w[i] && px[i]) begin
                done_wid[i] <= done_run[i];
                n_done[i]   <= n_done[i] + 1;
            end
        end
        pb <= busy_w;
        ps <= sclk_w;
        pr <= rclk_w;
        px <= done_w;
    end

    task automatic wait_xfer(input int idx, input int target, input string what);
        int k = 0;
        while (n_xfer[idx] < target && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (n_xfer[idx] < target) begin
            n_bad++;
            $display("FAIL %s: transfers seen %0d, required %0d (timeout)", what, n_xfer[idx], target);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        if0.data_in = 8'hA5; if1.data_in = 8'hA5; if2.data_in = 8'hA5;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({if0.sclk, if0.sdata, if0.rclk, if0.busy, if0.xfer_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000", {if0.sclk, if0.sdata, if0.rclk, if0.busy, if0.xfer_done});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL refresh_start: busy %b want 1", if0.busy); end
        wait_xfer(0, 1, "refresh_wait");
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy_len[0] !== 68) begin n_bad++; $display("FAIL refresh_busy_len: got %0d want 68", busy_len[0]); end
        n_cmp++; if (bits[0][7:0] !== 8'hA5) begin n_bad++; $display("FAIL refresh_bits: got %h want a5", bits[0][7:0]); end
        n_cmp++; if (first_lat[0] !== 4) begin n_bad++; $display("FAIL refresh_first_rise: got %0d want 4", first_lat[0]); end
        n_cmp++; if (n_rise[0] !== 8) begin n_bad++; $display("FAIL refresh_sclk_rises: got %0d want 8", n_rise[0]); end
        n_cmp++; if (n_rclk[0] !== 1) begin n_bad++; $display("FAIL refresh_rclk_count: got %0d want 1", n_rclk[0]); end
        n_cmp++; if (rclk_wid[0] !== 4) begin n_bad++; $display("FAIL refresh_rclk_width: got %0d want 4", rclk_wid[0]); end
        n_cmp++; if (n_done[0] !== 1) begin n_bad++; $display("FAIL refresh_done_count: got %0d want 1", n_done[0]); end
        n_cmp++; if (done_wid[0] !== 1) begin n_bad++; $display("FAIL refresh_done_width: got %0d want 1", done_wid[0]); end
    endtask

    task automatic test_stable;
        int c0 = busy_cyc[0];
        int r0 = n_rise[0];
        int l0 = n_rclk[0];
        repeat (500) @(negedge clk);
        #1;
        n_cmp++; if (busy_cyc[0] - c0 !== 0) begin n_bad++; $display("FAIL stable_busy: got %0d busy cycles want 0", busy_cyc[0] - c0); end
        n_cmp++; if (n_rise[0] - r0 !== 0) begin n_bad++; $display("FAIL stable_sclk: got %0d rises want 0", n_rise[0] - r0); end
        n_cmp++; if (n_rclk[0] - l0 !== 0) begin n_bad++; $display("FAIL stable_rclk: got %0d pulses want 0", n_rclk[0] - l0); end
    endtask

    task automatic test_change_mid;
        int x0 = n_xfer[0];
        if0.data_in = 8'h00;
        wait_xfer(0, x0 + 1, "chg_pre_wait");
        repeat (3) @(negedge clk);
        #1;
        x0 = n_xfer[0];
        if0.data_in = 8'hA5;
        @(posedge clk);
        repeat (10) @(negedge clk);
        #1;
        if0.data_in = 8'h3C;
        wait_xfer(0, x0 + 1, "chg_first_wait");
        n_cmp++; if (bits[0][7:0] !== 8'hA5) begin n_bad++; $display("FAIL chg_first_bits: got %h want a5", bits[0][7:0]); end
        n_cmp++; if (busy_len[0] !== 68) begin n_bad++; $display("FAIL chg_first_len: got %0d want 68", busy_len[0]); end
        wait_xfer(0, x0 + 2, "chg_second_wait");
        n_cmp++; if (gap[0] !== 1) begin n_bad++; $display("FAIL chg_idle_gap: got %0d want 1", gap[0]); end
        n_cmp++; if (bits[0][7:0] !== 8'h3C) begin n_bad++; $display("FAIL chg_second_bits: got %h want 3c", bits[0][7:0]); end
        n_cmp++; if (busy_len[0] !== 68) begin n_bad++; $display("FAIL chg_second_len: got %0d want 68", busy_len[0]); end
    endtask

    task automatic test_burst;
        int x0 = n_xfer[0];
        if0.data_in = 8'hFF;
        @(posedge clk);
        repeat (5) @(negedge clk);
        #1; if0.data_in = 8'h01;
        repeat (10) @(negedge clk);
        #1; if0.data_in = 8'h02;
        repeat (10) @(negedge clk);
        #1; if0.data_in = 8'h80;
        wait_xfer(0, x0 + 1, "burst_first_wait");
        n_cmp++; if (bits[0][7:0] !== 8'hFF) begin n_bad++; $display("FAIL burst_first_bits: got %h want ff", bits[0][7:0]); end
        wait_xfer(0, x0 + 2, "burst_second_wait");
        n_cmp++; if (bits[0][7:0] !== 8'h80) begin n_bad++; $display("FAIL burst_second_bits: got %h want 80", bits[0][7:0]); end
        repeat (200) @(negedge clk);
        #1;
        n_cmp++; if (n_xfer[0] - x0 !== 2) begin n_bad++; $display("FAIL burst_xfer_count: got %0d want 2", n_xfer[0] - x0); end
    endtask

    task automatic test_reset_mid;
        int x0 = n_xfer[0];
        int r0 = n_rclk[0];
        int s0 = n_rise[0];
        int k = 0;
        if0.data_in = 8'h55;
        while (n_rise[0] - s0 < 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (n_rise[0] - s0 < 3) begin n_bad++; $display("FAIL rstmid_third_rise: got %0d rises want 3", n_rise[0] - s0); end
        reset_n = 1'b0;
        if0.data_in = 8'hC3;
        #1;
        n_cmp++;
        if ({if0.sclk, if0.sdata, if0.rclk, if0.busy, if0.xfer_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %b want 00000", {if0.sclk, if0.sdata, if0.rclk, if0.busy, if0.xfer_done});
        end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (n_rclk[0] !== r0) begin n_bad++; $display("FAIL rstmid_no_latch: got %0d pulses want %0d", n_rclk[0], r0); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart: busy %b want 1", if0.busy); end
        wait_xfer(0, x0 + 2, "rstmid_wait");
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bits[0][7:0] !== 8'hC3) begin n_bad++; $display("FAIL rstmid_bits: got %h want c3", bits[0][7:0]); end
        n_cmp++; if (busy_len[0] !== 68) begin n_bad++; $display("FAIL rstmid_len: got %0d want 68", busy_len[0]); end
        n_cmp++; if (n_rclk[0] !== r0 + 1) begin n_bad++; $display("FAIL rstmid_rclk: got %0d pulses want %0d", n_rclk[0], r0 + 1); end
    endtask

    task automatic test_corners;
        int x1 = 0;
        int x2 = 0;
        int r2 = 0;
        repeat (5) @(negedge clk);
        #1;
        x1 = n_xfer[1];
        x2 = n_xfer[2];
        r2 = n_rise[2];
        if1.data_in = 8'h01;
        if2.data_in = 8'h96;
        wait_xfer(2, x2 + 1, "corner_div1_wait");
        wait_xfer(1, x1 + 1, "corner_lsb_wait");
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bits[1][7:0] !== 8'h80) begin n_bad++; $display("FAIL lsb_first_bits: got %h want 80", bits[1][7:0]); end
        n_cmp++; if (busy_len[1] !== 68) begin n_bad++; $display("FAIL lsb_first_len: got %0d want 68", busy_len[1]); end
        n_cmp++; if (bits[2][7:0] !== 8'h96) begin n_bad++; $display("FAIL div1_bits: got %h want 96", bits[2][7:0]); end
        n_cmp++; if (busy_len[2] !== 17) begin n_bad++; $display("FAIL div1_len: got %0d want 17", busy_len[2]); end
        n_cmp++; if (sclk_hi[2] !== 1) begin n_bad++; $display("FAIL div1_sclk_width: got %0d want 1", sclk_hi[2]); end
        n_cmp++; if (rclk_wid[2] !== 1) begin n_bad++; $display("FAIL div1_rclk_width: got %0d want 1", rclk_wid[2]); end
        n_cmp++; if (first_lat[2] !== 1) begin n_bad++; $display("FAIL div1_first_rise: got %0d want 1", first_lat[2]); end
        n_cmp++; if (n_rise[2] - r2 !== 8) begin n_bad++; $display("FAIL div1_sclk_rises: got %0d want 8", n_rise[2] - r2); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stable();
        test_change_mid();
        test_burst();
        test_reset_mid();
        test_corners();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_shift_out_595.md
# pio_shift_out_595

Serializer that sits directly downstream of the CPU system's 8-bit PIO output port. It watches the port value and, whenever it changes, shifts the new value out MSB-first over a 3-wire interface (serial clock, serial data, latch) to an external 74HC595-style shift/latch register driving the board LEDs. All outputs are registered, and the block always converges to the most recent port value. It also performs one unconditional refresh after reset so that the external register's power-up contents are overwritten.

## Interface
Parameters:
- DATA_W, 8: width of the parallel input and the number of bits shifted per transfer (1–32).
- CLK_DIV, 4: clk cycles per serial-clock half period (1–255).
- MSB_FIRST, 1: 1 = bit DATA_W-1 is shifted first; 0 = bit 0 is shifted first.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  parallel value from the PIO out_port, synchronous to clk.
- sclk  out  1  serial shift clock to the external register (data is sampled there on the rising edge).
- sdata  out  1  serial data.
- rclk  out  1  latch strobe; external outputs update on its rising edge.
- busy  out  1  high while a transfer (shift plus latch) is in progress.
- xfer_done  out  1  one-cycle pulse on the cycle busy falls.

## Operation
- Reset state:
  - sclk, sdata, rclk, busy, xfer_done = 0.
  - state = IDLE; sent_q = 0; refresh_q = 1.
- States: IDLE, SHIFT_LOW, SHIFT_HIGH, LATCH.
- IDLE:
  - Start condition: (refresh_q == 1) or (data_in != sent_q).
  - On start, at the same edge:
    - shreg <= data_in; sent_q <= data_in; refresh_q <= 0.
    - sdata <= first bit; bit_cnt <= 0; div_cnt <= 0; busy <= 1.
    - Go to SHIFT_LOW.
- SHIFT_LOW: sclk = 0 for CLK_DIV cycles, then go to SHIFT_HIGH.
- SHIFT_HIGH: sclk = 1 for CLK_DIV cycles. At the end of that window:
  - If bit_cnt == DATA_W-1: go to LATCH with sclk <= 0 and rclk <= 1.
  - Otherwise: bit_cnt++, shift shreg, sdata <= next bit, go to SHIFT_LOW with sclk <= 0.
- LATCH: rclk = 1 for CLK_DIV cycles. Then go to IDLE with rclk <= 0, busy <= 0, xfer_done <= 1.
- sdata changes only on the edge that drives sclk low (or at start), so it is stable for the whole CLK_DIV high window.
- Changes to data_in during a transfer are ignored by the shift. sent_q keeps the value that was captured at start. On return to IDLE the start condition is re-evaluated, so intermediate values are dropped and only the latest value is sent.
- data_in is in the clk domain; no synchronizer is required.

## Timing
- Start latency: the first sclk rise comes CLK_DIV cycles after the edge at which busy rises.
- Transfer length: busy stays high for exactly (2*DATA_W+1)*CLK_DIV cycles. With defaults that is 68 cycles.
- After every transfer there is at least 1 IDLE cycle (busy = 0) before the next start.
- sclk shows exactly DATA_W rising edges per transfer, and rclk shows exactly one pulse of width CLK_DIV.
- xfer_done is high for exactly 1 cycle, coincident with the first IDLE cycle.
- Reset asserted mid-transfer:
  - All outputs go to 0 immediately (asynchronous); the partial frame is never latched.
  - refresh_q = 1, so a full transfer of the current data_in starts on the first clk edge after reset_n deasserts.
- CLK_DIV = 1: sclk toggles every cycle and rclk is a 1-cycle pulse. There are no zero-length phases.
- A data_in change on the same edge as the IDLE -> SHIFT_LOW transition is captured, because capture uses data_in at that edge.

## Test plan
- Reset refresh: hold data_in = 0xA5 through reset release.
  - busy rises on the first edge and stays high 68 cycles.
  - sdata sampled at the sclk rises = 1,0,1,0,0,1,0,1.
  - One rclk pulse of 4 cycles, then one xfer_done pulse.
- Stable input: after the refresh, hold data_in = 0xA5 for 500 cycles. Required: no sclk, rclk, or busy activity.
- Change mid-transfer: change data_in to 0x3C at cycle 10 of a 0xA5 transfer.
  - The 0xA5 transfer completes unchanged.
  - Exactly 1 IDLE cycle follows, then a 0x3C transfer (bits 0,0,1,1,1,1,0,0).
- Burst collapse: during one transfer, write 0x01, 0x02, then 0x80. Required: exactly one follow-up transfer, carrying 0x80.
- Reset mid-shift: assert reset_n low after the 3rd sclk rise.
  - All outputs are 0 in the same cycle, and no rclk pulse occurs.
  - After release, a full transfer of the current data_in follows.
- Parameter corners: MSB_FIRST = 0 with 0xA5 gives bit order 1,0,1,0,0,1,0,1 (LSB first). CLK_DIV = 1 gives busy high 17 cycles and 8 sclk pulses each 1 cycle wide.
